alu_src_sel_stage: RTL and testbench
====================================

// Module: alu_src_sel_stage
// PURPOSE
//  Parametrised operand-source select stage feeding one ALU input.
//  Picks one of NUM_SRC source words, or a forwarded result, and registers it.
//  Registered output uses a 2-entry skid buffer with valid/ready handshakes on both sides.
//  Lets a pipelined OTTER datapath stall the ALU without losing operands.
//  Also flags out-of-range selects.
// PARAMETERS
//  WIDTH        32            data width of every source and of the output
//  NUM_SRC      4             number of selectable sources (>=2)
//  ILLEGAL_VAL  32'hDEADBEEF  output word when sel >= NUM_SRC (truncated to WIDTH)
//  SEL_W        $clog2(NUM_SRC) select width (localparam)
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              asynchronous reset, active-high
//  src_bus      in   NUM_SRC*WIDTH  source k at bits [k*WIDTH +: WIDTH]
//  sel          in   SEL_W          binary source index
//  fwd_en       in   1              forward override; takes priority over sel
//  fwd_data     in   WIDTH          forwarded result word
//  in_valid     in   1              upstream offers {src_bus,sel,fwd_*}
//  in_ready     out  1              stage can accept this cycle
//  out_data     out  WIDTH          selected operand
//  out_illegal  out  1              out_data came from an out-of-range sel
//  out_valid    out  1              out_data/out_illegal valid
//  out_ready    in   1              downstream ALU accepts
// BEHAVIOUR
//  Reset, RST asynchronous, active-high:
//   - main and skid entries are cleared.
//   - out_valid=0, out_data=0, out_illegal=0.
//   - in_ready=0 while RST is high; in_ready=1 on the first cycle after release.
//  Select, combinational, evaluated at capture:
//   - fwd_en=1 -> word=fwd_data, ill=0 (regardless of sel).
//   - else sel<NUM_SRC -> word=src_bus[sel], ill=0.
//   - else -> word=ILLEGAL_VAL, ill=1.
//  Handshakes:
//   - Input transfer when in_valid & in_ready.
//   - Output transfer when out_valid & out_ready.
//   - Inputs are sampled only on a transfer edge; later changes do not affect held data.
//  States (registered): EMPTY, ONE (main full), TWO (main+skid full).
//   - in_ready = (state!=TWO) & !RST. It depends only on state, with no comb path from out_ready.
//   - out_valid = (state!=EMPTY). out_data/out_illegal always reflect the main entry.
//  Transitions (in = input transfer, out = output transfer):
//   - EMPTY: in -> ONE.
//   - ONE: in & !out -> TWO, new word into skid.
//   - ONE: in & out -> ONE, main replaced by new word.
//   - ONE: !in & out -> EMPTY.
//   - ONE: neither -> hold.
//   - TWO: out -> ONE, skid moves to main. No input is accepted (in_ready=0).
//   - TWO: !out -> hold.
//  Latency and ordering:
//   - Latency 1 cycle: a word captured at edge N is on out_data after edge N when the stage is EMPTY.
//   - Throughput 1 word/cycle when out_ready is held high.
//   - Strict FIFO order; no word is dropped or duplicated.
//  Data rules:
//   - Main/skid entries hold {word, ill}.
//   - out_data is 0 when EMPTY.
//   - out_data holds stable while out_valid=1 and out_ready=0.
//  Reset mid-operation: all held words are discarded immediately and no transfer is reported.
//  Simultaneous fwd_en and illegal sel: forward wins, ill=0.
// TESTING
//  1. Reset then single word: NUM_SRC=4, src k=32'h1000+k, sel=2, one in_valid pulse, out_ready=1.
//     -> out_data=32'h1002 one cycle later; out_valid for one cycle.
//  2. Forward priority: fwd_en=1, fwd_data=32'hCAFE0001, sel=1.
//     -> out_data=32'hCAFE0001, out_illegal=0.
//  3. Illegal sel: NUM_SRC=3, sel=3, fwd_en=0.
//     -> out_data=32'hDEADBEEF, out_illegal=1.
//  4. Backpressure: out_ready=0, send A,B,C back-to-back.
//     -> A,B accepted; in_ready=0 on C, and C is held upstream.
//     -> raise out_ready: A,B,C emerge in order, no loss.
//  5. Streaming: in_valid=1, out_ready=1 for 16 cycles, sel cycling 0..3.
//     -> 16 outputs in order at 1/cycle; state never reaches TWO.
//  6. Async reset in TWO: assert RST between edges.
//     -> out_valid=0, out_data=0 immediately; in_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_src_sel_if.sv
// Handshake bundle between the operand producer, the source-select stage and the ALU.
// The producer/ALU side uses master; the stage uses slave.
interface alu_src_sel_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC);

    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic [SEL_W-1:0]         sel;
    logic                     fwd_en;
    logic [WIDTH-1:0]         fwd_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_illegal;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output src_bus, sel, fwd_en, fwd_data, in_valid, out_ready,
        input  in_ready, out_data, out_illegal, out_valid
    );

    modport slave (
        input  src_bus, sel, fwd_en, fwd_data, in_valid, out_ready,
        output in_ready, out_data, out_illegal, out_valid
    );
endinterface

// File: rtl/alu_src_sel_stage.sv
// Operand-source select stage for one ALU input: picks a source word or a forwarded
// result and holds it in a 2-entry skid buffer with valid/ready on both sides.
module alu_src_sel_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_SRC     = 4,
    parameter logic [31:0] ILLEGAL_VAL = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          rst,
    alu_src_sel_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_word_q, main_word_d;
    logic             main_ill_q, main_ill_d;
    logic [WIDTH-1:0] skid_word_q, skid_word_d;
    logic             skid_ill_q, skid_ill_d;

    logic [WIDTH-1:0] sel_word;
    logic             sel_ill;
    logic             accept;
    logic             in_fire;
    logic             out_fire;

    // Operand select: forward beats sel; anything past the last source is illegal.
    always_comb begin
        sel_word = WIDTH'(ILLEGAL_VAL);
        sel_ill  = 1'b1;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_word = bus.src_bus[k*WIDTH +: WIDTH];
                sel_ill  = 1'b0;
            end
        end
        if (bus.fwd_en) begin
            sel_word = bus.fwd_data;
            sel_ill  = 1'b0;
        end
    end

    // in_ready depends on state only, so no combinational path from out_ready.
    assign accept   = (state_q != TWO) && !rst;
    assign in_fire  = bus.in_valid && accept;
    assign out_fire = (state_q != EMPTY) && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_word_d = main_word_q;
        main_ill_d  = main_ill_q;
        skid_word_d = skid_word_q;
        skid_ill_d  = skid_ill_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_word_d = sel_word;
                    main_ill_d  = sel_ill;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d     = TWO;
                    skid_word_d = sel_word;
                    skid_ill_d  = sel_ill;
                end else if (in_fire && out_fire) begin
                    main_word_d = sel_word;
                    main_ill_d  = sel_ill;
                end else if (out_fire) begin
                    // Clear main so out_data reads zero while empty.
                    state_d     = EMPTY;
                    main_word_d = '0;
                    main_ill_d  = 1'b0;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_word_d = skid_word_q;
                    main_ill_d  = skid_ill_q;
                    skid_word_d = '0;
                    skid_ill_d  = 1'b0;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_word_d = '0;
                main_ill_d  = 1'b0;
                skid_word_d = '0;
                skid_ill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_word_q <= '0;
            main_ill_q  <= 1'b0;
            skid_word_q <= '0;
            skid_ill_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_word_q <= main_word_d;
            main_ill_q  <= main_ill_d;
            skid_word_q <= skid_word_d;
            skid_ill_q  <= skid_ill_d;
        end
    end

    assign bus.in_ready    = accept;
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_data    = main_word_q;
    assign bus.out_illegal = main_ill_q;

endmodule

// File: tb/tb_alu_src_sel_stage.sv
// Bench for alu_src_sel_stage: a 4-source and a 3-source instance driven in lockstep,
// checked against a queue model plus a table of fixed select vectors.
module tb_alu_src_sel_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_src_sel_if #(.WIDTH(32), .NUM_SRC(4)) if4 ();
    alu_src_sel_if #(.WIDTH(32), .NUM_SRC(3)) if3 ();

    alu_src_sel_stage #(.WIDTH(32), .NUM_SRC(4), .ILLEGAL_VAL(32'hDEADBEEF)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    alu_src_sel_stage #(.WIDTH(32), .NUM_SRC(3), .ILLEGAL_VAL(32'hDEADBEEF)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    typedef struct {
        logic [31:0] w;
        logic        ill;
    } entry_t;

    typedef struct {
        logic        fwd_en;
        logic [31:0] fwd_data;
        logic [1:0]  sel;
        logic [31:0] exp4;
        logic        ill4;
        logic [31:0] exp3;
        logic        ill3;
    } vec_t;

    entry_t q4[$];
    entry_t q3[$];
    int checks   = 0;
    int failures = 0;

    logic [127:0] src_fixed;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference select rule: forward wins, then in-range source, else illegal marker.
    function automatic entry_t ref_sel(input int nsrc, input logic [127:0] srcs,
                                       input logic fe, input logic [31:0] fd,
                                       input logic [1:0] s);
        entry_t e;
        int idx;
        idx = int'(s);
        if (fe) begin
            e.w = fd; e.ill = 1'b0;
        end else if (idx < nsrc) begin
            e.w = srcs[idx*32 +: 32]; e.ill = 1'b0;
        end else begin
            e.w = 32'hDEADBEEF; e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic iv, input logic orr, input logic [1:0] s,
                         input logic fe, input logic [31:0] fd, input logic [127:0] srcs);
        if4.in_valid = iv;   if3.in_valid = iv;
        if4.out_ready = orr; if3.out_ready = orr;
        if4.sel = s;         if3.sel = s;
        if4.fwd_en = fe;     if3.fwd_en = fe;
        if4.fwd_data = fd;   if3.fwd_data = fd;
        if4.src_bus = srcs;  if3.src_bus = srcs[95:0];
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_valid4"}, 32'(if4.out_valid), 32'(q4.size() > 0));
        chk({tag, "_data4"},  if4.out_data, (q4.size() > 0) ? q4[0].w : 32'h0);
        chk({tag, "_ill4"},   32'(if4.out_illegal), (q4.size() > 0) ? 32'(q4[0].ill) : 32'h0);
        chk({tag, "_valid3"}, 32'(if3.out_valid), 32'(q3.size() > 0));
        chk({tag, "_data3"},  if3.out_data, (q3.size() > 0) ? q3[0].w : 32'h0);
        chk({tag, "_ill3"},   32'(if3.out_illegal), (q3.size() > 0) ? 32'(q3[0].ill) : 32'h0);
    endtask

    // One clock: predict handshakes from the model, advance it at the edge, then compare.
    task automatic cycle(input string tag);
        entry_t e4, e3;
        bit in_f, out_f;
        e4 = ref_sel(4, if4.src_bus, if4.fwd_en, if4.fwd_data, if4.sel);
        e3 = ref_sel(3, {32'h0, if3.src_bus}, if3.fwd_en, if3.fwd_data, if3.sel);
        chk({tag, "_in_ready4"}, 32'(if4.in_ready), 32'(q4.size() < 2));
        chk({tag, "_in_ready3"}, 32'(if3.in_ready), 32'(q3.size() < 2));
        in_f  = if4.in_valid && (q4.size() < 2);
        out_f = if4.out_ready && (q4.size() > 0);
        @(posedge clk);
        if (out_f) begin
            void'(q4.pop_front());
            void'(q3.pop_front());
        end
        if (in_f) begin
            q4.push_back(e4);
            q3.push_back(e3);
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        src_fixed = {32'h00001003, 32'h00001002, 32'h00001001, 32'h00001000};
        vecs[0] = '{1'b0, 32'h0,        2'd0, 32'h00001000, 1'b0, 32'h00001000, 1'b0};
        vecs[1] = '{1'b0, 32'h0,        2'd2, 32'h00001002, 1'b0, 32'h00001002, 1'b0};
        vecs[2] = '{1'b0, 32'h0,        2'd3, 32'h00001003, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{1'b1, 32'hCAFE0001, 2'd1, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0};
        vecs[4] = '{1'b1, 32'h12345678, 2'd3, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
        vecs[5] = '{1'b0, 32'h0,        2'd1, 32'h00001001, 1'b0, 32'h00001001, 1'b0};

        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, src_fixed);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready4", 32'(if4.in_ready), 32'h0);
        chk("rst_in_ready3", 32'(if3.in_ready), 32'h0);
        check_outs("rst");
        rst = 1'b0;
        #1;
        chk("rel_in_ready4", 32'(if4.in_ready), 32'h1);

        // Single words through an empty stage, checked against fixed expectations.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, vecs[i].sel, vecs[i].fwd_en, vecs[i].fwd_data, src_fixed);
            cycle("vec_cap");
            chk($sformatf("vec%0d_data4", i), if4.out_data, vecs[i].exp4);
            chk($sformatf("vec%0d_ill4", i),  32'(if4.out_illegal), 32'(vecs[i].ill4));
            chk($sformatf("vec%0d_data3", i), if3.out_data, vecs[i].exp3);
            chk($sformatf("vec%0d_ill3", i),  32'(if3.out_illegal), 32'(vecs[i].ill3));
            chk($sformatf("vec%0d_valid", i), 32'(if4.out_valid), 32'h1);
            drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, src_fixed);
            cycle("vec_drain");
            chk($sformatf("vec%0d_empty", i), 32'(if4.out_valid), 32'h0);
        end

        // Backpressure: A,B fill the buffer, C is held upstream until space frees.
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'hA0A0A0A0, src_fixed); cycle("bp_a");
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'hB0B0B0B0, src_fixed); cycle("bp_b");
        drive(1'b1, 1'b0, 2'd0, 1'b1, 32'hC0C0C0C0, src_fixed);
        chk("bp_c_blocked", 32'(if4.in_ready), 32'h0);
        cycle("bp_hold");
        chk("bp_hold_a", if4.out_data, 32'hA0A0A0A0);
        drive(1'b1, 1'b1, 2'd0, 1'b1, 32'hC0C0C0C0, src_fixed); cycle("bp_pop_a");
        chk("bp_b_next", if4.out_data, 32'hB0B0B0B0);
        cycle("bp_c_in");
        chk("bp_c_next", if4.out_data, 32'hC0C0C0C0);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, src_fixed); cycle("bp_drain");
        chk("bp_empty", 32'(if4.out_valid), 32'h0);

        // Streaming at one word per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 2'(i), 1'b0, 32'h0, {$urandom, $urandom, $urandom, $urandom});
            cycle("stream");
        end
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, src_fixed); cycle("stream_drain");

        // Async reset while full.
        drive(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, src_fixed); cycle("ar_fill1");
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, src_fixed); cycle("ar_fill2");
        chk("ar_full", 32'(if4.in_ready), 32'h0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, src_fixed);
        #2;
        rst = 1'b1;
        q4.delete();
        q3.delete();
        #1;
        check_outs("ar_now");
        chk("ar_in_ready", 32'(if4.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_rel_in_ready4", 32'(if4.in_ready), 32'h1);
        chk("ar_rel_in_ready3", 32'(if3.in_ready), 32'h1);
        check_outs("ar_rel");

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  2'($urandom), 1'($urandom_range(0, 3) == 0), $urandom,
                  {$urandom, $urandom, $urandom, $urandom});
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
